rr_vn_lock_arb: RTL and testbench
=================================

RR_VN_LOCK_ARB -- requirements
Module: rr_vn_lock_arb

Interface
- REQ-001: Parameter NUM_VC, default 1, virtual channels per virtual network.
- REQ-002: Parameter NUM_VN, default 3, number of virtual networks.
- REQ-003: Derived N = NUM_VC*NUM_VN requesters; W = Log2(N), minimum 1; requester index i = vn*NUM_VC + vc.
- REQ-004: clk  input  1  single clock; all state updates on rising edge.
- REQ-005: rst_n  input  1  reset, asynchronous and active-low.
- REQ-006: req  input  N  per-requester flit-pending request.
- REQ-007: tail  input  N  per-requester "current flit is tail" flag; only meaningful where req is high.
- REQ-008: ack  input  1  downstream accepted the granted requester's flit this cycle.
- REQ-009: grant  output  N  registered one-hot grant, or all-zero.
- REQ-010: grant_valid  output  1  registered; equals |grant.
- REQ-011: grant_id  output  W  registered binary index of the granted bit; 0 when grant_valid=0.

Function
- REQ-012: FSM has exactly two states, IDLE and LOCKED; grant_valid=1 iff state is LOCKED.
- REQ-013: Round-robin pointer ptr (W bits, range 0..N-1) marks the highest-priority index; priority descends ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
- REQ-014: IDLE, req=0: stay IDLE; grant=0; ptr unchanged.
- REQ-015: IDLE, req!=0: select the first asserted req in pointer order; next cycle grant is one-hot on the winner, grant_id holds the winner's index, and state is LOCKED (1-cycle request-to-grant latency).
- REQ-016: LOCKED: grant, grant_id held constant regardless of other req changes (packet lock, no interleaving).
- REQ-017: LOCKED, ack=1 and tail[grant_id]=1: next cycle state IDLE, grant=0, ptr=(grant_id+1) mod N.
- REQ-018: LOCKED, ack=1 and tail[grant_id]=0: remain LOCKED; body flit consumed.
- REQ-019: LOCKED, ack=0: remain LOCKED regardless of tail.
- REQ-020: LOCKED, req[grant_id]=0 and ack=0: abort, i.e. next cycle IDLE, grant=0, ptr=(grant_id+1) mod N.
- REQ-021: LOCKED, req[grant_id]=0 and ack=1: treated as release per REQ-017 irrespective of tail.
- REQ-022: After release, one IDLE bubble cycle always precedes the next grant (release at t, grant low at t+1, new grant at earliest t+2).
- REQ-023: ptr changes only on release or abort, never in IDLE.
- REQ-024: Wrap-around: grant_id=N-1 released gives ptr=0.
- REQ-025: N=1: ptr constant 0; the lock and release rules still apply.
- REQ-026: Fairness: any continuously asserted requester is granted within N arbitration rounds.
- REQ-027: grant is never multi-hot; grant_id and grant always agree.
- REQ-028: ack while IDLE has no effect.

Reset
- REQ-029: rst_n=0 asynchronously forces state=IDLE, ptr=0, grant=0, grant_valid=0, grant_id=0, including while LOCKED mid-packet.
- REQ-030: After rst_n deasserts, arbitration starts on the first rising edge with req!=0, from ptr=0.

Verification (N=3 unless stated)
- REQ-031: After reset, req=3'b110 -> next cycle grant=3'b010, grant_id=1, grant_valid=1.
- REQ-032: Lock: grant on 1 with req=3'b111; 3 cycles ack=1, tail=0, then ack=1, tail[1]=1 -> grant stays 3'b010 through the tail cycle, then 0 for one cycle, then 3'b100 (ptr=2).
- REQ-033: Wrap and fairness: all req held high, single-flit packets (tail=3'b111, ack=1 each LOCKED cycle) -> grant sequence 001,0,010,0,100,0,001.
- REQ-034: Abort: locked on 0, req[0] drops with ack=0 -> next cycle grant=0, then grant=3'b010 if req[1]=1.
- REQ-035: Async reset: assert rst_n=0 between edges while LOCKED -> grant=0 immediately without a clock edge; after release, req=3'b100 -> grant=3'b100.
- REQ-036: NUM_VN=2, NUM_VC=2 (N=4): req=4'b1000 granted and released -> ptr=0; then req=4'b1001 -> grant=4'b0001.

Source files
------------

// File: rtl/rr_vn_lock_arb_if.sv
// Request/grant bundle between requesters and the packet-locking arbiter.
// master drives requests and ack; slave is the arbiter side.
interface rr_vn_lock_arb_if #(
    parameter int N = 3,
    parameter int W = (N > 1) ? $clog2(N) : 1
) ();
    logic [N-1:0] req;
    logic [N-1:0] tail;
    logic         ack;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [W-1:0] grant_id;

    modport master (
        output req, tail, ack,
        input  grant, grant_valid, grant_id
    );

    modport slave (
        input  req, tail, ack,
        output grant, grant_valid, grant_id
    );
endinterface

// File: rtl/rr_vn_lock_arb.sv
// Round-robin arbiter over NUM_VN*NUM_VC requesters that holds its grant
// for a whole packet, releasing on an acked tail flit or a dropped request.
module rr_vn_lock_arb #(
    parameter int NUM_VC = 1,
    parameter int NUM_VN = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    rr_vn_lock_arb_if.slave   bus
);
    localparam int N = NUM_VC * NUM_VN;
    localparam int W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W:0]   NW   = (W + 1)'(N);
    localparam logic [W-1:0] LAST = W'(N - 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t       state_q, state_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic [W-1:0] gid_q, gid_d;
    logic [N-1:0] grant_q, grant_d;

    logic [W:0]   idx;
    logic [W-1:0] win;
    logic         hit;
    logic         cur_req;
    logic         cur_tail;
    logic         release_now;
    logic [W-1:0] nxt_ptr;

    // Scan ptr, ptr+1, ... with wrap; the first pending request wins.
    always_comb begin
        idx = '0;
        win = '0;
        hit = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr_q} + (W + 1)'(k);
            if (idx >= NW) idx = idx - NW;
            if (!hit && bus.req[idx[W-1:0]]) begin
                hit = 1'b1;
                win = idx[W-1:0];
            end
        end
    end

    assign cur_req  = bus.req[gid_q];
    assign cur_tail = bus.tail[gid_q];
    // A vanished request releases the lock whether or not it was acked.
    assign release_now = !cur_req || (bus.ack && cur_tail);
    assign nxt_ptr = (gid_q == LAST) ? '0 : gid_q + W'(1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        grant_d = grant_q;
        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d      = LOCKED;
                    gid_d        = win;
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                end
            end
            LOCKED: begin
                if (release_now) begin
                    state_d = IDLE;
                    ptr_d   = nxt_ptr;
                    gid_d   = '0;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gid_d   = '0;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gid_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            grant_q <= grant_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = (state_q == LOCKED);
    assign bus.grant_id    = gid_q;
endmodule

// File: tb/tb_rr_vn_lock_arb.sv
// Bench for rr_vn_lock_arb: directed scenarios on N=3 and N=4 instances
// plus a random run against a cycle-level reference model.
module tb_rr_vn_lock_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    rr_vn_lock_arb_if #(.N(3)) b3 ();
    rr_vn_lock_arb_if #(.N(4)) b4 ();

    rr_vn_lock_arb #(.NUM_VC(1), .NUM_VN(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(b3)
    );
    rr_vn_lock_arb #(.NUM_VC(2), .NUM_VN(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(b4)
    );

    // Reference model for the N=3 instance, kept as plain integers.
    int m_lock, m_ptr, m_gid;

    function automatic logic [2:0] m_grant();
        logic [2:0] g;
        g = '0;
        if (m_lock != 0) g[m_gid] = 1'b1;
        return g;
    endfunction

    task automatic model_step();
        logic [2:0] r, t;
        logic a;
        r = b3.req;
        t = b3.tail;
        a = b3.ack;
        if (m_lock == 0) begin
            for (int k = 0; k < 3; k++) begin
                int i;
                i = (m_ptr + k) % 3;
                if (m_lock == 0 && r[i]) begin
                    m_lock = 1;
                    m_gid = i;
                end
            end
        end else if (!r[m_gid] || (a && t[m_gid])) begin
            m_ptr = (m_gid + 1) % 3;
            m_lock = 0;
            m_gid = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic [2:0] r, input logic [2:0] t,
                         input logic a);
        b3.req = r;
        b3.tail = t;
        b3.ack = a;
    endtask

    task automatic do_reset();
        drive(3'b000, 3'b000, 1'b0);
        b4.req = '0;
        b4.tail = '0;
        b4.ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        m_lock = 0;
        m_ptr = 0;
        m_gid = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if (b3.grant !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_grant got %b want 000", b3.grant);
        end
        n_chk++;
        if (b3.grant_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid got %b want 0", b3.grant_valid);
        end
        n_chk++;
        if (b3.grant_id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_id got %0d want 0", b3.grant_id);
        end
        // ack while idle must not do anything
        drive(3'b000, 3'b111, 1'b1);
        step();
        n_chk++;
        if (b3.grant !== 3'b000 || b3.grant_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ack got %b/%b want 000/0",
                     b3.grant, b3.grant_valid);
        end
    endtask

    task automatic test_first_grant();
        do_reset();
        drive(3'b110, 3'b000, 1'b0);
        step();
        n_chk++;
        if (b3.grant !== 3'b010 || b3.grant_id !== 2'd1
            || b3.grant_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL first_grant got %b id %0d v %b want 010 id 1 v 1",
                     b3.grant, b3.grant_id, b3.grant_valid);
        end
    endtask

    task automatic test_lock();
        do_reset();
        drive(3'b110, 3'b000, 1'b0);
        step();
        drive(3'b111, 3'b000, 1'b1);
        for (int c = 0; c < 3; c++) begin
            step();
            n_chk++;
            if (b3.grant !== 3'b010) begin
                n_fail++;
                $display("FAIL lock_body%0d got %b want 010", c, b3.grant);
            end
        end
        drive(3'b111, 3'b010, 1'b1);
        n_chk++;
        if (b3.grant !== 3'b010) begin
            n_fail++;
            $display("FAIL lock_tail got %b want 010", b3.grant);
        end
        step();
        n_chk++;
        if (b3.grant !== 3'b000 || b3.grant_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_bubble got %b want 000", b3.grant);
        end
        drive(3'b111, 3'b000, 1'b0);
        step();
        n_chk++;
        if (b3.grant !== 3'b100 || b3.grant_id !== 2'd2) begin
            n_fail++;
            $display("FAIL lock_next got %b id %0d want 100 id 2",
                     b3.grant, b3.grant_id);
        end
    endtask

    task automatic test_wrap();
        logic [2:0] exp_seq [7];
        exp_seq = '{3'b001, 3'b000, 3'b010, 3'b000,
                    3'b100, 3'b000, 3'b001};
        do_reset();
        drive(3'b111, 3'b111, 1'b1);
        for (int c = 0; c < 7; c++) begin
            step();
            n_chk++;
            if (b3.grant !== exp_seq[c]) begin
                n_fail++;
                $display("FAIL wrap%0d got %b want %b",
                         c, b3.grant, exp_seq[c]);
            end
        end
    endtask

    task automatic test_abort();
        do_reset();
        drive(3'b001, 3'b000, 1'b0);
        step();
        n_chk++;
        if (b3.grant !== 3'b001) begin
            n_fail++;
            $display("FAIL abort_lock got %b want 001", b3.grant);
        end
        drive(3'b010, 3'b000, 1'b0);
        step();
        n_chk++;
        if (b3.grant !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_drop got %b want 000", b3.grant);
        end
        step();
        n_chk++;
        if (b3.grant !== 3'b010 || b3.grant_id !== 2'd1) begin
            n_fail++;
            $display("FAIL abort_next got %b id %0d want 010 id 1",
                     b3.grant, b3.grant_id);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(3'b010, 3'b000, 1'b0);
        step();
        #2;
        rst_n = 1'b0;
        m_lock = 0;
        m_ptr = 0;
        m_gid = 0;
        #1;
        n_chk++;
        if (b3.grant !== 3'b000 || b3.grant_valid !== 1'b0
            || b3.grant_id !== 2'd0) begin
            n_fail++;
            $display("FAIL async_rst got %b v %b id %0d want 000 v 0 id 0",
                     b3.grant, b3.grant_valid, b3.grant_id);
        end
        drive(3'b100, 3'b000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_chk++;
        if (b3.grant !== 3'b100) begin
            n_fail++;
            $display("FAIL async_after got %b want 100", b3.grant);
        end
    endtask

    task automatic test_n4();
        do_reset();
        b4.req = 4'b1000;
        step();
        n_chk++;
        if (b4.grant !== 4'b1000 || b4.grant_id !== 2'd3) begin
            n_fail++;
            $display("FAIL n4_grant got %b id %0d want 1000 id 3",
                     b4.grant, b4.grant_id);
        end
        b4.ack = 1'b1;
        b4.tail = 4'b1000;
        step();
        n_chk++;
        if (b4.grant !== 4'b0000) begin
            n_fail++;
            $display("FAIL n4_release got %b want 0000", b4.grant);
        end
        b4.ack = 1'b0;
        b4.tail = 4'b0000;
        b4.req = 4'b1001;
        step();
        n_chk++;
        if (b4.grant !== 4'b0001 || b4.grant_id !== 2'd0) begin
            n_fail++;
            $display("FAIL n4_wrap got %b id %0d want 0001 id 0",
                     b4.grant, b4.grant_id);
        end
        b4.req = 4'b0000;
    endtask

    task automatic test_random();
        logic [2:0] eg;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            drive(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)));
            step();
            eg = m_grant();
            n_chk++;
            if (b3.grant !== eg || b3.grant_valid !== (m_lock != 0)
                || b3.grant_id !== 2'(m_gid)) begin
                n_fail++;
                $display("FAIL rand%0d got %b v %b id %0d want %b v %0d id %0d",
                         c, b3.grant, b3.grant_valid, b3.grant_id,
                         eg, m_lock, m_gid);
            end
        end
    endtask

    initial begin
        drive(3'b000, 3'b000, 1'b0);
        b4.req = '0;
        b4.tail = '0;
        b4.ack = 1'b0;
        m_lock = 0;
        m_ptr = 0;
        m_gid = 0;
        test_reset();
        test_first_grant();
        test_lock();
        test_wrap();
        test_abort();
        test_async_reset();
        test_n4();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
